ifu_bht_update_ctl: RTL and testbench

- Consumer side of the EXU branch-resolution output: takes resolved conditional-branch updates (index, new 2-bit history, mispredict flag) and writes them into the IFU branch history table (BHT).
- Updates are buffered in a small FIFO. BHT read lookups have priority over the BHT write port, so writes drain only when the BHT port is idle.
- Coalesces back-to-back updates to the same index. Keeps mispredict and drop statistics.

---
 rtl/ifu_bht_update_ctl.sv | 136 +++++++++++++
 tb/tb_ifu_bht_update_ctl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_bht_update_ctl.sv
// ifu_bht_update_ctl
//   Buffers resolved conditional-branch history updates from the EXU and
//   writes them into the IFU branch history table whenever the BHT port is
//   not taken by a fetch lookup. Back-to-back updates to the same index
//   collapse into the tail entry. Mispredicts and dropped updates are counted.
//
//   Optional build macro: BHT_UPD_BYPASS_EN
//     When defined, an update that arrives while the FIFO is empty and the
//     BHT port is free is written to the BHT in the same cycle without
//     being enqueued. When undefined, every update passes through the FIFO.
module ifu_bht_update_ctl #(
  parameter int INDEX_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [1:0]         upd_hist,
  input  logic               upd_misp,
  input  logic               bht_rd_busy,
  output logic               bht_wr_en,
  output logic [INDEX_W-1:0] bht_wr_addr,
  output logic [1:0]         bht_wr_data,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic [15:0]        misp_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [1:0]         hist;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count;

  logic               pop;
  logic               push;
  logic               coalesce;
  logic               drop;
  logic               bypass;
  entry_t             head;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign head     = mem[rd_ptr];

  // A fetch lookup owns the BHT port; writes only drain when it is idle.
  assign pop = ~empty & ~bht_rd_busy;

`ifdef BHT_UPD_BYPASS_EN
  assign bypass = upd_valid & empty & ~bht_rd_busy;
`else
  assign bypass = 1'b0;
`endif

  // Same index as the tail merges into it, unless the tail is the head
  // entry leaving this cycle (then the new update needs its own slot).
  assign coalesce = upd_valid & ~empty & (mem[tail_ptr].index == upd_index) &
                    ((count >= CNT_W'(2)) | ~pop);

  // A full FIFO still accepts when the head retires in the same cycle.
  assign push = upd_valid & ~bypass & ~coalesce & (~full | pop);
  assign drop = upd_valid & full & ~pop & ~coalesce;

  // BHT write port: head entry on a pop, zeros when nothing is buffered.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would infer a latch.
    bht_wr_en   = pop;
    bht_wr_addr = '0;
    bht_wr_data = '0;
    if (!empty) begin
      bht_wr_addr = head.index;
      bht_wr_data = head.hist;
    end
`ifdef BHT_UPD_BYPASS_EN
    if (bypass) begin
      bht_wr_en   = 1'b1;
      bht_wr_addr = upd_index;
      bht_wr_data = upd_hist;
    end
`endif
  end

  // Pointers, occupancy and statistics.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      misp_cnt <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (upd_valid && upd_misp && misp_cnt != 16'hFFFF)
        misp_cnt <= misp_cnt + 16'd1;
    end
  end

  // Entry storage: new entries land at wr_ptr, coalesces rewrite the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count gates every read, so
    // stale contents are never observed and the array can map to plain RAM.
    if (!rst) begin
      if (push)
        mem[wr_ptr] <= '{index: upd_index, hist: upd_hist};
      else if (coalesce)
        mem[tail_ptr].hist <= upd_hist;
    end
  end

endmodule

// File: tb/tb_ifu_bht_update_ctl.sv
// Self-checking bench for ifu_bht_update_ctl: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model through
// a write scoreboard. Build with +define+BHT_UPD_BYPASS_EN for the bypass build.
module tb_ifu_bht_update_ctl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [7:0]  upd_index = '0;
  logic [1:0]  upd_hist = '0;
  logic        upd_misp = 1'b0;
  logic        bht_rd_busy = 1'b0;
  logic        bht_wr_en;
  logic [7:0]  bht_wr_addr;
  logic [1:0]  bht_wr_data;
  logic        empty, full, overflow;
  logic [7:0]  drop_cnt;
  logic [15:0] misp_cnt;

  ifu_bht_update_ctl #(.INDEX_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hist(upd_hist),
    .upd_misp(upd_misp), .bht_rd_busy(bht_rd_busy),
    .bht_wr_en(bht_wr_en), .bht_wr_addr(bht_wr_addr), .bht_wr_data(bht_wr_data),
    .empty(empty), .full(full), .overflow(overflow),
    .drop_cnt(drop_cnt), .misp_cnt(misp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] idx; logic [1:0] hist; } ent_t;
  typedef struct { int cyc; logic [7:0] addr; logic [1:0] data; } wr_t;

  ent_t fifo[$];     // model contents, head at [0]
  wr_t  exp_q[$];    // expected BHT writes with the cycle they must occur in
  int   m_drop = 0;
  int   m_misp = 0;
  bit   m_ovf  = 0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: verify state left by the previous edge, drive the
  // inputs for this cycle and advance the model to the state after the edge.
  task automatic step(input bit v, input logic [7:0] idx, input logic [1:0] hist,
                      input bit misp, input bit busy);
    int n;
    bit pop_e, byp, coal;
    @(posedge clk); #1;
    check("empty",    empty,    fifo.size() == 0);
    check("full",     full,     fifo.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    check("misp_cnt", misp_cnt, m_misp);
    upd_valid = v; upd_index = idx; upd_hist = hist; upd_misp = misp; bht_rd_busy = busy;

    n     = fifo.size();
    pop_e = (n > 0) && !busy;
    byp   = 1'b0;
`ifdef BHT_UPD_BYPASS_EN
    byp = v && (n == 0) && !busy;
`endif
    if (byp)   exp_q.push_back('{cyc: cyc, addr: idx, data: hist});
    if (pop_e) exp_q.push_back('{cyc: cyc, addr: fifo[0].idx, data: fifo[0].hist});
    coal = v && (n >= 1) && (fifo[n-1].idx == idx) && ((n >= 2) || !pop_e);
    if (coal) fifo[n-1].hist = hist;
    if (pop_e) void'(fifo.pop_front());
    if (v && !coal && !byp) begin
      if (n < DEPTH || pop_e) fifo.push_back('{idx: idx, hist: hist});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (v && misp && m_misp < 65535) m_misp++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    upd_valid = 1'b0; upd_misp = 1'b0; bht_rd_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fifo.delete(); exp_q.delete();
    m_drop = 0; m_misp = 0; m_ovf = 1'b0;
    check("rst_wr_en",    bht_wr_en,   0);
    check("rst_wr_addr",  bht_wr_addr, 0);
    check("rst_wr_data",  bht_wr_data, 0);
    check("rst_empty",    empty,       1);
    check("rst_overflow", overflow,    0);
    check("rst_drop_cnt", drop_cnt,    0);
    check("rst_misp_cnt", misp_cnt,    0);
  endtask

  // Write monitor: on every cycle compare the BHT write port with the
  // scoreboard entry due in this cycle (if any).
  initial begin
    wr_t w;
    bit  due;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("wr_en", bht_wr_en, due);
        if (due) begin
          w = exp_q.pop_front();
          if (bht_wr_en === 1'b1) begin
            check("wr_addr", bht_wr_addr, w.addr);
            check("wr_data", bht_wr_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    bit busy_mode = 1'b0;
    do_reset();

    // Single update, then idle.
    step(1, 8'h12, 2'b10, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    // Busy backlog: four entries fill the FIFO, the fifth is dropped.
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 2'(i), 0, 1);
    step(0, 0, 0, 0, 1);
    check("backlog_full", full, 1);
    check("backlog_drop", drop_cnt, 1);
    check("backlog_ovf",  overflow, 1);
    repeat (6) step(0, 0, 0, 0, 0);

    // Coalesce two updates to one index while the port is busy.
    do_reset();
    step(1, 8'h20, 2'b01, 0, 1);
    step(1, 8'h20, 2'b11, 0, 1);
    step(0, 0, 0, 0, 1);
    check("coal_count1", {full, empty}, 2'b00);
    repeat (3) step(0, 0, 0, 0, 0);

    // Full FIFO with a simultaneous pop accepts the new update.
    for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 2'(i), 0, 1);
    step(1, 8'h30, 2'b01, 0, 0);
    step(0, 0, 0, 0, 0);
    check("fullpop_nodrop", drop_cnt, 0);
    repeat (6) step(0, 0, 0, 0, 0);

    // Saturating counters: 300 mispredicted updates dropped.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h01 + 8'(i), 2'b00, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 8'h80 + 8'(i % 64), 2'b11, 1, 1);
    step(0, 0, 0, 0, 1);
    check("sat_drop_cnt", drop_cnt, 255);
    check("sat_misp_cnt", misp_cnt, 300);

    // Reset mid-operation with three entries buffered; nothing stale drains.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'h50 + 8'(i), 2'b10, 1, 1);
    do_reset();
    repeat (5) step(0, 0, 0, 0, 0);

    // Randomized traffic with a narrow index range to exercise coalescing.
    for (int i = 0; i < 2000; i++) begin
      bit v, busy;
      logic [7:0] idx;
      if (i == 1000) do_reset();
      if ($urandom_range(0, 15) == 0) busy_mode = ~busy_mode;
      busy = busy_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      v    = ($urandom_range(0, 2) != 0);
      idx  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      step(v, idx, 2'($urandom), bit'($urandom), busy);
    end
    repeat (8) step(0, 0, 0, 0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
